// File: rtl/skew_buffer.sv
// skew_buffer: diagonal skew (lane i delayed i cycles) or deskew (lane i delayed N-1-i) stage for the systolic array edge.
// Latency: 1 + D(i) enabled cycles per lane; a common input register means no lane is combinational.
// Backpressure: en=0 stalls every register, the FSM and the drain counter; drain_done is held low while stalled.
// Optional build macro SKEW_BUF_ZERO_GATE_EN: when defined, a lane's out_data is forced to 0 while its out_valid is 0.
module skew_buffer #(
  parameter int N      = 8,
  parameter int DW     = 8,
  parameter int DESKEW = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            in_valid,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]    out_valid,
  output logic [N*DW-1:0] out_data,
  output logic            busy,
  output logic            drain_done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;

  logic            in_vld_q;
  logic [N*DW-1:0] in_dat_q;
  logic [N-1:0]    lane_busy;

  // Common input register shared by every lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vld_q <= 1'b0;
      in_dat_q <= '0;
    end else if (en) begin
      in_vld_q <= in_valid;
      in_dat_q <= in_data;
    end
  end

  // Per-lane delay lines: D extra stages after the input register.
  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int D = (DESKEW != 0) ? (N - 1 - i) : i;

    logic [DW-1:0] lane_dat;

    if (D == 0) begin : g_pass
      assign out_valid[i]  = in_vld_q;
      assign lane_dat      = in_dat_q[i*DW +: DW];
      // The input register valid is already folded into busy directly.
      assign lane_busy[i]  = 1'b0;
    end else begin : g_shift
      logic [D-1:0]  vld_sr;
      logic [DW-1:0] dat_sr [D];

      // Shift the {valid, data} pair one stage per enabled cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_sr <= '0;
          for (int k = 0; k < D; k++) begin
            dat_sr[k] <= '0;
          end
        end else if (en) begin
          vld_sr[0] <= in_vld_q;
          dat_sr[0] <= in_dat_q[i*DW +: DW];
          for (int k = 1; k < D; k++) begin
            vld_sr[k] <= vld_sr[k-1];
            dat_sr[k] <= dat_sr[k-1];
          end
        end
      end

      assign out_valid[i] = vld_sr[D-1];
      assign lane_dat     = dat_sr[D-1];
      assign lane_busy[i] = |vld_sr;
    end

`ifdef SKEW_BUF_ZERO_GATE_EN
    // Feed zeros into the array MACs while a lane is filling or draining.
    assign out_data[i*DW +: DW] = out_valid[i] ? lane_dat : '0;
`else
    // Data passes through untouched; consumers qualify it with out_valid.
    assign out_data[i*DW +: DW] = lane_dat;
`endif
  end

  // FSM state and drain counter; both freeze on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter update and the drain completion pulse.
  // DRAIN starts one cycle after the last beat was sampled with cnt=N. The
  // last beat reaches the longest lane's output N-1 cycles after that, which
  // is the cycle in which cnt sits at 2 and its decrement lands on 1.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drain_done = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        cnt_d = '0;
        if (!in_valid) begin
          state_d = DRAIN;
          cnt_d   = CW'(N);
        end
      end
      DRAIN: begin
        if (in_valid) begin
          // A new burst cancels the drain without a completion pulse.
          state_d = STREAM;
          cnt_d   = '0;
        end else if (cnt_q <= CW'(2)) begin
          drain_done = en;
          state_d    = IDLE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Busy covers the FSM plus every valid bit still in flight.
  assign busy = (state_q != IDLE) | in_vld_q | (|lane_busy);

endmodule

// File: tb/tb_skew_buffer.sv
// tb_skew_buffer: directed checks of skew and deskew builds of skew_buffer (N=4, DW=8).
// Inputs change 1 time unit after the rising edge, outputs are sampled 3 units after it.
// Both instances share stimulus; each scenario task compares against hand-computed values.
module tb_skew_buffer;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic            in_valid;
  logic [N*DW-1:0] in_data;

  logic [N-1:0]    ov_s, ov_d;
  logic [N*DW-1:0] od_s, od_d;
  logic            busy_s, busy_d;
  logic            dd_s, dd_d;

  int n_checks;
  int n_fail;

  skew_buffer #(.N(N), .DW(DW), .DESKEW(0)) u_skew (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (ov_s),
    .out_data   (od_s),
    .busy       (busy_s),
    .drain_done (dd_s)
  );

  skew_buffer #(.N(N), .DW(DW), .DESKEW(1)) u_desk (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (ov_d),
    .out_data   (od_d),
    .busy       (busy_d),
    .drain_done (dd_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      in_valid = 1'b0;
      in_data  = '0;
      en       = 1'b1;
      next_cycle();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (ov_s !== 4'h0) begin n_fail++; $display("FAIL reset_ov_s got %h want 0", ov_s); end
    n_checks++; if (od_s !== 32'h0) begin n_fail++; $display("FAIL reset_od_s got %h want 0", od_s); end
    n_checks++; if (busy_s !== 1'b0) begin n_fail++; $display("FAIL reset_busy_s got %b want 0", busy_s); end
    n_checks++; if (dd_s !== 1'b0) begin n_fail++; $display("FAIL reset_dd_s got %b want 0", dd_s); end
    n_checks++; if (ov_d !== 4'h0) begin n_fail++; $display("FAIL reset_ov_d got %h want 0", ov_d); end
    n_checks++; if (od_d !== 32'h0) begin n_fail++; $display("FAIL reset_od_d got %h want 0", od_d); end
    // Reset must dominate an enabled, valid input across a clock edge.
    en = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    next_cycle();
    #2;
    n_checks++; if (ov_s !== 4'h0) begin n_fail++; $display("FAIL reset_dom_ov got %h want 0", ov_s); end
    n_checks++; if (busy_s !== 1'b0) begin n_fail++; $display("FAIL reset_dom_busy got %b want 0", busy_s); end
    n_checks++; if (od_d !== 32'h0) begin n_fail++; $display("FAIL reset_dom_od_d got %h want 0", od_d); end
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0;
    next_cycle();
  endtask

  task automatic test_skew_burst();
    logic [3:0] exp_v;
    for (int c = 0; c <= 6; c++) begin
      en = 1'b1;
      in_valid = (c == 0);
      in_data  = (c == 0) ? 32'h4030_2010 : 32'h0;
      #2;
      exp_v = (c >= 1 && c <= 4) ? 4'(1 << (c - 1)) : 4'h0;
      n_checks++; if (ov_s !== exp_v) begin n_fail++; $display("FAIL skew_ov c%0d got %h want %h", c, ov_s, exp_v); end
      if (c >= 1 && c <= 4) begin
        n_checks++;
        if (od_s[(c-1)*DW +: DW] !== 8'(c * 16)) begin
          n_fail++; $display("FAIL skew_data c%0d got %h want %h", c, od_s[(c-1)*DW +: DW], 8'(c * 16));
        end
      end
      n_checks++; if (dd_s !== (c == 4)) begin n_fail++; $display("FAIL skew_done c%0d got %b want %b", c, dd_s, (c == 4)); end
      n_checks++; if (busy_s !== (c >= 1 && c <= 4)) begin n_fail++; $display("FAIL skew_busy c%0d got %b want %b", c, busy_s, (c >= 1 && c <= 4)); end
      next_cycle();
    end
  endtask

  task automatic test_deskew_burst();
    logic [3:0] exp_v;
    int         lane;
    for (int c = 0; c <= 6; c++) begin
      en = 1'b1;
      in_valid = (c == 0);
      in_data  = (c == 0) ? 32'h4030_2010 : 32'h0;
      #2;
      lane  = 4 - c;
      exp_v = (c >= 1 && c <= 4) ? 4'(1 << lane) : 4'h0;
      n_checks++; if (ov_d !== exp_v) begin n_fail++; $display("FAIL deskew_ov c%0d got %h want %h", c, ov_d, exp_v); end
      if (c >= 1 && c <= 4) begin
        n_checks++;
        if (od_d[lane*DW +: DW] !== 8'((lane + 1) * 16)) begin
          n_fail++; $display("FAIL deskew_data c%0d got %h want %h", c, od_d[lane*DW +: DW], 8'((lane + 1) * 16));
        end
      end
      n_checks++; if (dd_d !== (c == 4)) begin n_fail++; $display("FAIL deskew_done c%0d got %b want %b", c, dd_d, (c == 4)); end
      n_checks++; if (busy_d !== (c >= 1 && c <= 4)) begin n_fail++; $display("FAIL deskew_busy c%0d got %b want %b", c, busy_d, (c >= 1 && c <= 4)); end
      next_cycle();
    end
  endtask

  // Beats A,B then two stalled cycles, then C. Table nibbles are {l3,l2,l1,l0} beat codes.
  task automatic test_stall();
    logic [15:0] exp_tab [10];
    logic [3:0]  nib;
    exp_tab = '{16'h0000, 16'h000A, 16'h00AB, 16'h00AB, 16'h00AB,
                16'h0ABC, 16'hABC0, 16'hBC00, 16'hC000, 16'h0000};
    for (int c = 0; c < 10; c++) begin
      en       = !(c == 2 || c == 3);
      in_valid = (c <= 4);
      case (c)
        0:       in_data = 32'hA3A2_A1A0;
        1:       in_data = 32'hB3B2_B1B0;
        2, 3, 4: in_data = 32'hC3C2_C1C0;
        default: in_data = 32'h0;
      endcase
      #2;
      for (int i = 0; i < N; i++) begin
        nib = exp_tab[c][i*4 +: 4];
        n_checks++;
        if (ov_s[i] !== (nib != 4'h0)) begin n_fail++; $display("FAIL stall_ov c%0d lane%0d got %b want %b", c, i, ov_s[i], (nib != 4'h0)); end
        if (nib != 4'h0) begin
          n_checks++;
          if (od_s[i*DW +: DW] !== {nib, 4'(i)}) begin
            n_fail++; $display("FAIL stall_data c%0d lane%0d got %h want %h", c, i, od_s[i*DW +: DW], {nib, 4'(i)});
          end
        end
      end
      n_checks++; if (dd_s !== (c == 8)) begin n_fail++; $display("FAIL stall_done c%0d got %b want %b", c, dd_s, (c == 8)); end
      n_checks++; if (busy_s !== (c >= 1 && c <= 8)) begin n_fail++; $display("FAIL stall_busy c%0d got %b want %b", c, busy_s, (c >= 1 && c <= 8)); end
      next_cycle();
    end
  endtask

  // Beats A,B, two idle cycles (drain starts), then C,D cancel the drain.
  task automatic test_drain_cancel();
    logic [15:0] exp_tab [11];
    logic [3:0]  nib;
    exp_tab = '{16'h0000, 16'h000A, 16'h00AB, 16'h0AB0, 16'hAB00, 16'hB00C,
                16'h00CD, 16'h0CD0, 16'hCD00, 16'hD000, 16'h0000};
    for (int c = 0; c < 11; c++) begin
      en       = 1'b1;
      in_valid = (c == 0 || c == 1 || c == 4 || c == 5);
      case (c)
        0:       in_data = 32'hA3A2_A1A0;
        1:       in_data = 32'hB3B2_B1B0;
        4:       in_data = 32'hC3C2_C1C0;
        5:       in_data = 32'hD3D2_D1D0;
        default: in_data = 32'h0;
      endcase
      #2;
      for (int i = 0; i < N; i++) begin
        nib = exp_tab[c][i*4 +: 4];
        n_checks++;
        if (ov_s[i] !== (nib != 4'h0)) begin n_fail++; $display("FAIL cancel_ov c%0d lane%0d got %b want %b", c, i, ov_s[i], (nib != 4'h0)); end
        if (nib != 4'h0) begin
          n_checks++;
          if (od_s[i*DW +: DW] !== {nib, 4'(i)}) begin
            n_fail++; $display("FAIL cancel_data c%0d lane%0d got %h want %h", c, i, od_s[i*DW +: DW], {nib, 4'(i)});
          end
        end
      end
      n_checks++; if (dd_s !== (c == 9)) begin n_fail++; $display("FAIL cancel_done c%0d got %b want %b", c, dd_s, (c == 9)); end
      n_checks++; if (busy_s !== (c >= 1 && c <= 9)) begin n_fail++; $display("FAIL cancel_busy c%0d got %b want %b", c, busy_s, (c >= 1 && c <= 9)); end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 2; c++) begin
      en = 1'b1; in_valid = 1'b1; in_data = 32'h5A5A_5A5A;
      next_cycle();
    end
    en = 1'b1; in_valid = 1'b1; in_data = 32'h5A5A_5A5A;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ov_s !== 4'h0) begin n_fail++; $display("FAIL areset_ov_s got %h want 0", ov_s); end
    n_checks++; if (od_s !== 32'h0) begin n_fail++; $display("FAIL areset_od_s got %h want 0", od_s); end
    n_checks++; if (busy_s !== 1'b0) begin n_fail++; $display("FAIL areset_busy_s got %b want 0", busy_s); end
    n_checks++; if (ov_d !== 4'h0) begin n_fail++; $display("FAIL areset_ov_d got %h want 0", ov_d); end
    n_checks++; if (od_d !== 32'h0) begin n_fail++; $display("FAIL areset_od_d got %h want 0", od_d); end
    n_checks++; if (busy_d !== 1'b0) begin n_fail++; $display("FAIL areset_busy_d got %b want 0", busy_d); end
    #1;
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0;
    next_cycle();
    for (int c = 0; c < 8; c++) begin
      en = 1'b1; in_valid = 1'b0; in_data = '0;
      #2;
      n_checks++; if (dd_s !== 1'b0 || dd_d !== 1'b0) begin n_fail++; $display("FAIL areset_done c%0d got %b%b want 00", c, dd_s, dd_d); end
      n_checks++; if (ov_s !== 4'h0 || busy_s !== 1'b0) begin n_fail++; $display("FAIL areset_idle c%0d got ov=%h busy=%b want ov=0 busy=0", c, ov_s, busy_s); end
      next_cycle();
    end
  endtask

  // Invalid beats carrying 0xFF on every lane; data regs hold 0 beforehand.
  task automatic test_zero_gate();
    logic [31:0] exp_s1, exp_d1, exp_all;
`ifdef SKEW_BUF_ZERO_GATE_EN
    exp_s1 = 32'h0; exp_d1 = 32'h0; exp_all = 32'h0;
`else
    exp_s1 = 32'h0000_00FF; exp_d1 = 32'hFF00_0000; exp_all = 32'hFFFF_FFFF;
`endif
    for (int c = 0; c < 6; c++) begin
      en = 1'b1; in_valid = 1'b0; in_data = 32'hFFFF_FFFF;
      #2;
      if (c == 1) begin
        n_checks++; if (od_s !== exp_s1) begin n_fail++; $display("FAIL zgate_s_c1 got %h want %h", od_s, exp_s1); end
        n_checks++; if (od_d !== exp_d1) begin n_fail++; $display("FAIL zgate_d_c1 got %h want %h", od_d, exp_d1); end
      end
      if (c == 5) begin
        n_checks++; if (od_s !== exp_all) begin n_fail++; $display("FAIL zgate_s got %h want %h", od_s, exp_all); end
        n_checks++; if (od_d !== exp_all) begin n_fail++; $display("FAIL zgate_d got %h want %h", od_d, exp_all); end
        n_checks++; if (ov_s !== 4'h0 || ov_d !== 4'h0) begin n_fail++; $display("FAIL zgate_ov got %h/%h want 0/0", ov_s, ov_d); end
      end
      next_cycle();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    idle(2);
    test_skew_burst();
    idle(4);
    test_deskew_burst();
    idle(4);
    test_stall();
    idle(4);
    test_drain_cancel();
    idle(4);
    test_async_reset();
    test_zero_gate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
